lu_cache_arbiter: RTL
=====================

Name: lu_cache_arbiter

Overview:
Shares one LU cache between REQ_COUNT requesters using round-robin arbitration. For each granted request it works out hit/miss and the match position from the cache contents, then pulses the cache's new_data to apply the update. It tracks how many cache entries are valid, so reset-value contents never false-hit, and supports a logical flush. It sits between the requester interfaces and the cache's data_in / new_data / data_out ports.

Parameters:
CELL_SIZE, 8, width of one cache entry
CELL_COUNT, 8, number of cache entries
CELL_ADDR_SIZE, 3, width of an entry index (log2 CELL_COUNT)
REQ_COUNT, 4, number of requesters
REQ_ID_SIZE, 2, width of a requester id (log2 REQ_COUNT)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  REQ_COUNT  per-requester request valid
req_data  in  REQ_COUNT*CELL_SIZE  requester k data at [k*CELL_SIZE +: CELL_SIZE]
req_ready  out  REQ_COUNT  one-hot grant; transfer when req_valid[k] & req_ready[k]
flush_req  in  1  level request to invalidate all entries
flush_ack  out  1  one-cycle pulse when the flush completes
cache_data_in  out  CELL_SIZE  to cache data_in
cache_new_data  out  1  to cache new_data; one-cycle pulse
cache_data_out  in  CELL_COUNT*CELL_SIZE  from cache; entry i at [i*CELL_SIZE +: CELL_SIZE], entry 0 = most recent
rsp_valid  out  1  one-cycle response strobe
rsp_id  out  REQ_ID_SIZE  id of the requester being answered
rsp_hit  out  1  1 = hit
rsp_pos  out  CELL_ADDR_SIZE  hit index; 0 on a miss
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE; fill_count=0; rr_ptr=0.
  - All outputs 0: cache_data_in, cache_new_data, rsp_*, flush_ack, req_ready, busy.
  - Any in-flight request is dropped and produces no rsp.
- FSM states: IDLE, LOOKUP, RESP, FLUSH.
- IDLE:
  - If flush_req=1: go to FLUSH. No grant is issued (flush has priority over requests).
  - Else if any req_valid: winner = first k with req_valid[k], searching from rr_ptr upward with wrap.
    - req_ready[winner]=1 combinationally in this cycle only.
    - At the clock edge: latch id and data (cache_data_in <= data), then go to LOOKUP.
  - req_ready is 0 in every other state.
- LOOKUP (1 cycle):
  - cache_new_data=1.
  - Compare the latched data against entries i < fill_count.
  - hit = any match; pos = lowest matching i.
  - Register hit and pos at the edge, then go to RESP.
- RESP (1 cycle):
  - rsp_valid=1 with rsp_id, rsp_hit, rsp_pos (pos=0 on a miss).
  - On a miss: fill_count <= min(fill_count+1, CELL_COUNT), saturating at CELL_COUNT.
  - rr_ptr <= (id+1) mod REQ_COUNT.
  - Go to IDLE.
- FLUSH (1 cycle):
  - fill_count <= 0; flush_ack=1.
  - Go to IDLE.
  - Cache contents are untouched; they are only logically invalid.
- flush_req raised during LOOKUP/RESP is held pending and serviced in the next IDLE, before any request.
- Throughput is one request per 3 cycles. Grant-to-rsp latency is 2 cycles after the grant edge.
- cache_data_in holds the last latched value between requests.

Test Plan:
- Reset: assert reset=0 mid-stream -> all outputs 0 immediately. After release, IDLE with busy=0 and fill_count=0. Deassert during LOOKUP -> no rsp_valid.
- Single miss after reset: req 2 with data 0x00, cache model all-zero -> req_ready=0b0100 for one cycle; cache_new_data one cycle; next cycle rsp_valid=1, id=2, hit=0, pos=0 (no false hit on zeros).
- Round-robin: all four req_valid held high -> grant order 0,1,2,3,0, one grant every 3 cycles, each rsp_id matching its grant.
- Hit position: misses 0xA1, 0xB2, 0xC3 (cache model shifts on miss) then request 0xA1 -> rsp_hit=1, rsp_pos=2.
- Saturation: 9 distinct misses then request the first value -> rsp_hit=0 (value evicted) and fill_count stays 8.
- Flush priority: flush_req and req_valid[1] both high in IDLE -> flush_ack first and no grant that cycle; grant to requester 1 in the next IDLE cycle. A repeat of a previously cached value after the flush -> miss.

Source files
------------

// File: rtl/lu_cache_arbiter_if.sv
`default_nettype none
// ============================================================================
// lu_cache_arbiter_if : requester, flush and cache-side bus of lu_cache_arbiter
// Revision 1.0
// ============================================================================
interface lu_cache_arbiter_if #(
    parameter int CELL_SIZE      = 8,
    parameter int CELL_COUNT     = 8,
    parameter int CELL_ADDR_SIZE = 3,
    parameter int REQ_COUNT      = 4,
    parameter int REQ_ID_SIZE    = 2
);
    logic [REQ_COUNT-1:0]            req_valid;
    logic [REQ_COUNT*CELL_SIZE-1:0]  req_data;
    logic [REQ_COUNT-1:0]            req_ready;
    logic                            flush_req;
    logic                            flush_ack;
    logic [CELL_SIZE-1:0]            cache_data_in;
    logic                            cache_new_data;
    logic [CELL_COUNT*CELL_SIZE-1:0] cache_data_out;
    logic                            rsp_valid;
    logic [REQ_ID_SIZE-1:0]          rsp_id;
    logic                            rsp_hit;
    logic [CELL_ADDR_SIZE-1:0]       rsp_pos;
    logic                            busy;

    // master = environment (requesters + cache), slave = the arbiter
    modport master (
        output req_valid, req_data, flush_req, cache_data_out,
        input  req_ready, flush_ack, cache_data_in, cache_new_data,
               rsp_valid, rsp_id, rsp_hit, rsp_pos, busy
    );

    modport slave (
        input  req_valid, req_data, flush_req, cache_data_out,
        output req_ready, flush_ack, cache_data_in, cache_new_data,
               rsp_valid, rsp_id, rsp_hit, rsp_pos, busy
    );
endinterface
`default_nettype wire

// File: rtl/lu_cache_arbiter.sv
`default_nettype none
// ============================================================================
// lu_cache_arbiter : round-robin sharing of one LU cache, hit/miss + position
// Revision 1.0
// ============================================================================
module lu_cache_arbiter #(
    parameter int CELL_SIZE      = 8,
    parameter int CELL_COUNT     = 8,
    parameter int CELL_ADDR_SIZE = 3,
    parameter int REQ_COUNT      = 4,
    parameter int REQ_ID_SIZE    = 2
) (
    input  logic                clk,
    input  logic                reset,
    lu_cache_arbiter_if.slave   bus
);
    localparam int FILL_W = CELL_ADDR_SIZE + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_RESP   = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [FILL_W-1:0]         r_fill;
    logic [REQ_ID_SIZE-1:0]    r_rr;
    logic [REQ_ID_SIZE-1:0]    r_id;
    logic [CELL_SIZE-1:0]      r_data;
    logic                      r_hit;
    logic [CELL_ADDR_SIZE-1:0] r_pos;
    logic                      r_flush_pend;

    logic                      w_any;
    logic [REQ_ID_SIZE-1:0]    w_win;
    logic [REQ_ID_SIZE-1:0]    w_idx;
    logic                      w_hit;
    logic [CELL_ADDR_SIZE-1:0] w_pos;
    logic [REQ_COUNT-1:0]      w_ready;
    logic                      w_flush;

    assign w_flush = bus.flush_req | r_flush_pend;

    // Walk offsets from high to low so the smallest offset from r_rr wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int i = REQ_COUNT - 1; i >= 0; i--) begin
            w_idx = r_rr + REQ_ID_SIZE'(i);
            if (bus.req_valid[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    // Only the first r_fill entries are valid; stale contents never match.
    always_comb begin
        w_hit = 1'b0;
        w_pos = '0;
        for (int i = CELL_COUNT - 1; i >= 0; i--) begin
            if ((FILL_W'(i) < r_fill) &&
                (bus.cache_data_out[i*CELL_SIZE +: CELL_SIZE] == r_data)) begin
                w_hit = 1'b1;
                w_pos = CELL_ADDR_SIZE'(i);
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_flush) begin
                    w_next = ST_FLUSH;
                end else if (w_any) begin
                    w_next = ST_LOOKUP;
                    w_ready[w_win] = reset;
                end
            end
            ST_LOOKUP: w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            ST_FLUSH:  w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_fill       <= '0;
            r_rr         <= '0;
            r_id         <= '0;
            r_data       <= '0;
            r_hit        <= 1'b0;
            r_pos        <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_next == ST_LOOKUP) begin
                        r_id   <= w_win;
                        r_data <= bus.req_data[w_win*CELL_SIZE +: CELL_SIZE];
                    end
                end
                ST_LOOKUP: begin
                    r_hit <= w_hit;
                    r_pos <= w_pos;
                    if (bus.flush_req) r_flush_pend <= 1'b1;
                end
                ST_RESP: begin
                    if (!r_hit && (r_fill != FILL_W'(CELL_COUNT)))
                        r_fill <= r_fill + FILL_W'(1);
                    r_rr <= r_id + REQ_ID_SIZE'(1);
                    if (bus.flush_req) r_flush_pend <= 1'b1;
                end
                ST_FLUSH: begin
                    r_fill       <= '0;
                    r_flush_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready      = w_ready;
    assign bus.cache_data_in  = r_data;
    assign bus.cache_new_data = (r_state == ST_LOOKUP);
    assign bus.rsp_valid      = (r_state == ST_RESP);
    assign bus.rsp_id         = r_id;
    assign bus.rsp_hit        = r_hit;
    assign bus.rsp_pos        = r_pos;
    assign bus.flush_ack      = (r_state == ST_FLUSH);
    assign bus.busy           = (r_state != ST_IDLE);

endmodule
`default_nettype wire
